updown_mod_counter: RTL and testbench

Parametrised synchronous up/down counter with parallel load, runtime modulus limit, wrap or saturate mode, and a terminal-count pulse. Generalises the team's fixed 8-bit loadable counter in three ways: width, count direction and boundary handling. Sits behind the top-level wrapper, driving a uo_out-style status bus and acting as a timebase for downstream event logic.

---
 rtl/updown_mod_counter_pkg.sv | 9 +
 rtl/updown_mod_counter_prescale_divider.sv | 20 ++
 rtl/updown_mod_counter.sv | 57 +++++
 tb/tb_updown_mod_counter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/updown_mod_counter_pkg.sv
// updown_mod_counter_pkg: shared mode/direction encodings and default sizes for updown_mod_counter
package updown_mod_counter_pkg;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP = 1'b1;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_PRESCALE_W = 4;
endpackage

// File: rtl/updown_mod_counter_prescale_divider.sv
// prescale_divider: emits one tick every prescale+1 enabled cycles; clr restarts the period
module prescale_divider
  import updown_mod_counter_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);
  logic [PRESCALE_W-1:0] div;
  assign tick = en && (div == prescale);
  always_ff @(posedge clk) begin
    if (reset || clr) div <= '0;
    else if (en) div <= tick ? '0 : div + 1'b1;
  end
endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: loadable up/down counter over [0, limit] with wrap/saturate and terminal-count pulse
// Define UDCNT_PRESCALE_EN to build the step prescaler; otherwise prescale is ignored.
module updown_mod_counter
  import updown_mod_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  up,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  sat_mode,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc
);
  logic step;
`ifdef UDCNT_PRESCALE_EN
  prescale_divider #(.PRESCALE_W(PRESCALE_W)) u_div (
    .clk(clk),
    .reset(reset),
    .en(en),
    .clr(load),
    .prescale(prescale),
    .tick(step)
  );
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale;
  assign step = en;
`endif
  logic at_bound;
  logic [WIDTH-1:0] load_clamp, next_up, next_down;
  always_comb begin
    at_bound = (up == DIR_UP) ? (count >= limit) : (count == '0);
    load_clamp = (load_val > limit) ? limit : load_val;
    next_up = at_bound ? ((sat_mode == MODE_SAT) ? limit : '0) : count + 1'b1;
    // a count left above a lowered limit is pulled back to the limit first
    next_down = (count > limit) ? limit : at_bound ? ((sat_mode == MODE_SAT) ? '0 : limit) : count - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tc <= 1'b0;
    end else if (load) begin
      count <= load_clamp;
      tc <= 1'b0;
    end else begin
      if (step) count <= (up == DIR_UP) ? next_up : next_down;
      tc <= step && at_bound;
    end
  end
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed self-checking bench for updown_mod_counter (WIDTH=8)
module tb_updown_mod_counter;
  logic clk = 1'b0;
  logic reset, en, load, up, sat_mode;
  logic [7:0] load_val, limit, count;
  logic [3:0] prescale;
  logic tc;
  int checks = 0;
  int failures = 0;

  updown_mod_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .load(load),
    .load_val(load_val),
    .up(up),
    .limit(limit),
    .sat_mode(sat_mode),
    .prescale(prescale),
    .count(count),
    .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp_count, input logic exp_tc);
    checks++;
    assert (count === exp_count) else begin
      failures++;
      $error("FAIL %s count: got %0h expected %0h", tag, count, exp_count);
    end
    checks++;
    assert (tc === exp_tc) else begin
      failures++;
      $error("FAIL %s tc: got %0b expected %0b", tag, tc, exp_tc);
    end
  endtask

  task automatic do_load(input logic [7:0] v, input logic [7:0] lim);
    en = 1'b0;
    load = 1'b1;
    load_val = v;
    limit = lim;
    tick();
    load = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_c1 [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
    logic exp_t1 [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] exp_c2 [4] = '{8'd1, 8'd0, 8'd0, 8'd0};
    logic exp_t2 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    reset = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; up = 1'b1;
    limit = 8'd5; sat_mode = 1'b0; prescale = '0;
    tick();
    chk("reset", 8'd0, 1'b0);
    reset = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("wrap_up[%0d]", i), exp_c1[i], exp_t1[i]);
    end
    do_load(8'd2, 8'd200);
    chk("load2", 8'd2, 1'b0);
    en = 1'b1; up = 1'b0; sat_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("sat_down[%0d]", i), exp_c2[i], exp_t2[i]);
    end
    en = 1'b1; load = 1'b1; load_val = 8'h80; limit = 8'hFF; up = 1'b1;
    tick();
    chk("load_prio", 8'h80, 1'b0);
    load_val = 8'd250; limit = 8'd100;
    tick();
    chk("load_clamp", 8'd100, 1'b0);
    do_load(8'h37, 8'hFF);
    en = 1'b1; up = 1'b1; sat_mode = 1'b0;
    tick();
    chk("run_37", 8'h38, 1'b0);
    reset = 1'b1; load = 1'b1; load_val = 8'h10;
    tick();
    chk("reset_over_load", 8'h00, 1'b0);
    reset = 1'b0; load = 1'b0;
    tick();
    chk("resume", 8'h01, 1'b0);
    do_load(8'd10, 8'd200);
    en = 1'b1; up = 1'b1; sat_mode = 1'b0; limit = 8'd3;
    tick();
    chk("drop_up_wrap", 8'd0, 1'b1);
    do_load(8'd10, 8'd200);
    en = 1'b1; up = 1'b1; sat_mode = 1'b1; limit = 8'd3;
    tick();
    chk("drop_up_sat", 8'd3, 1'b1);
    do_load(8'd10, 8'd200);
    en = 1'b1; up = 1'b0; sat_mode = 1'b0; limit = 8'd3;
    tick();
    chk("drop_down", 8'd3, 1'b0);
    tick();
    chk("down_after_drop", 8'd2, 1'b0);
    en = 1'b0;
    tick();
    chk("hold", 8'd2, 1'b0);
    do_load(8'd7, 8'd0);
    chk("load_lim0", 8'd0, 1'b0);
    en = 1'b1; up = 1'b1;
    tick();
    chk("lim0_up", 8'd0, 1'b1);
    up = 1'b0;
    tick();
    chk("lim0_down", 8'd0, 1'b1);
    do_load(8'd4, 8'd9);
    en = 1'b1; up = 1'b0; sat_mode = 1'b0;
    tick();
    chk("dir_down", 8'd3, 1'b0);
    up = 1'b1;
    tick();
    chk("dir_up", 8'd4, 1'b0);
`ifdef UDCNT_PRESCALE_EN
    prescale = 4'd2;
    do_load(8'd0, 8'd200);
    en = 1'b1; up = 1'b1; sat_mode = 1'b0;
    tick(); chk("ps_a1", 8'd0, 1'b0);
    tick(); chk("ps_a2", 8'd0, 1'b0);
    tick(); chk("ps_a3", 8'd1, 1'b0);
    tick(); chk("ps_b1", 8'd1, 1'b0);
    en = 1'b0;
    tick(); chk("ps_pause1", 8'd1, 1'b0);
    tick(); chk("ps_pause2", 8'd1, 1'b0);
    en = 1'b1;
    tick(); chk("ps_b2", 8'd1, 1'b0);
    tick(); chk("ps_b3", 8'd2, 1'b0);
    tick(); chk("ps_c1", 8'd2, 1'b0);
    do_load(8'd5, 8'd200);
    en = 1'b1;
    tick(); chk("ps_l1", 8'd5, 1'b0);
    tick(); chk("ps_l2", 8'd5, 1'b0);
    tick(); chk("ps_l3", 8'd6, 1'b0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
